// File: rtl/rv32_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: owner tags, FSM states, in-flight tag.
package rv32_arb_pkg;

  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_e;

  typedef enum logic {MEM_PRI = 1'b0, IF_PRI = 1'b1} arb_state_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
    logic   is_wr;
  } tag_t;

  localparam logic [2:0] IF_UBHW = 3'b010;

  // Width of the starvation counter; a limit of 0 still needs a 1-bit flop.
  function automatic int starve_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rv32_arb_tag_pipe.sv
// DEPTH-stage shift register of in-flight tags; stage DEPTH-1 lines up with RAM read data.
module rv32_arb_tag_pipe
  import rv32_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/rv32_mem_arbiter.sv
// IF/MEM arbiter for a single RAM port with MEM priority and an IF starvation guard.
// Optional performance counters are built when RV32_ARB_PERF_EN is defined.
module rv32_mem_arbiter
  import rv32_arb_pkg::*;
#(
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 3,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic              mem_req_we,
  input  logic [2:0]        mem_req_ubhw,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_rsp_valid,
  output logic [31:0]       mem_rsp_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [2:0]        ram_ubhw,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [PERF_W-1:0] perf_conflicts,
  output logic [PERF_W-1:0] perf_if_wait
);

  localparam int            CW        = starve_w(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_CNT = CW'(STARVE_LIMIT);

  arb_state_e    state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;
  logic          conflict, if_gnt, mem_gnt, rsp_live;
  tag_t          tag_in, tag_out;

  assign conflict = if_req_valid && mem_req_valid;

  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    if (!rst) begin
      if (state == MEM_PRI) begin
        mem_gnt = mem_req_valid;
        if_gnt  = if_req_valid && !mem_req_valid;
      end else begin
        if_gnt  = if_req_valid;
        mem_gnt = mem_req_valid && !if_req_valid;
      end
    end
  end

  assign if_req_ready  = if_gnt;
  assign mem_req_ready = mem_gnt;

  // The counter saturates at the limit; with a limit of 0 it never leaves 0.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    if (if_gnt)
      starve_cnt_nxt = '0;
    else if (conflict && mem_gnt && starve_cnt != LIMIT_CNT)
      starve_cnt_nxt = starve_cnt + 1'b1;
    case (state)
      MEM_PRI: if (STARVE_LIMIT > 0 && starve_cnt_nxt == LIMIT_CNT) state_nxt = IF_PRI;
      IF_PRI:  if (if_gnt) state_nxt = MEM_PRI;
      default: state_nxt = MEM_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MEM_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_ubhw  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (mem_gnt) begin
      ram_en    = 1'b1;
      ram_we    = mem_req_we;
      ram_ubhw  = mem_req_ubhw;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end else if (if_gnt) begin
      ram_en   = 1'b1;
      ram_ubhw = IF_UBHW;
      ram_addr = if_addr;
    end
  end

  assign tag_in.vld   = if_gnt || mem_gnt;
  assign tag_in.owner = mem_gnt ? OWN_MEM : OWN_IF;
  assign tag_in.is_wr = mem_gnt && mem_req_we;

  rv32_arb_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Responses are masked during reset so the retiring stage cannot leak out before the clear edge.
  assign rsp_live      = tag_out.vld && !rst;
  assign if_rsp_valid  = rsp_live && (tag_out.owner == OWN_IF);
  assign if_rsp_data   = if_rsp_valid ? ram_rdata : 32'h0;
  assign mem_rsp_valid = rsp_live && (tag_out.owner == OWN_MEM);
  assign mem_rsp_data  = (mem_rsp_valid && !tag_out.is_wr) ? ram_rdata : 32'h0;

`ifdef RV32_ARB_PERF_EN
  logic [PERF_W-1:0] conf_q, wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conf_q <= '0;
      wait_q <= '0;
    end else begin
      if (conflict && conf_q != '1) conf_q <= conf_q + 1'b1;
      if (if_req_valid && !if_req_ready && wait_q != '1) wait_q <= wait_q + 1'b1;
    end
  end

  assign perf_conflicts = rst ? '0 : conf_q;
  assign perf_if_wait   = rst ? '0 : wait_q;
`else
  assign perf_conflicts = '0;
  assign perf_if_wait   = '0;
`endif

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: RAM model plus an in-order response scoreboard.
module tb_rv32_mem_arbiter;
  import rv32_arb_pkg::*;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, mem_req_valid, mem_req_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [2:0]  mem_req_ubhw;

  logic        if_req_ready, if_rsp_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] if_rsp_data, mem_rsp_data, ram_addr, ram_wdata, ram_rdata;
  logic        ram_en, ram_we;
  logic [2:0]  ram_ubhw;
  logic [31:0] perf_conflicts, perf_if_wait;

  logic        s0_if_req_ready, s0_if_rsp_valid, s0_mem_req_ready, s0_mem_rsp_valid;
  logic [31:0] s0_if_rsp_data, s0_mem_rsp_data, s0_ram_addr, s0_ram_wdata;
  logic        s0_ram_en, s0_ram_we;
  logic [2:0]  s0_ram_ubhw;
  logic [31:0] s0_perf_conflicts, s0_perf_if_wait;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIMIT(3), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_ubhw(mem_req_ubhw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_ubhw(ram_ubhw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .perf_conflicts(perf_conflicts), .perf_if_wait(perf_if_wait)
  );

  // Strict-MEM-priority instance sharing the same request stimulus.
  rv32_mem_arbiter #(.RD_LAT(1), .STARVE_LIMIT(0), .PERF_W(32)) dut_s0 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(s0_if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(s0_if_rsp_valid), .if_rsp_data(s0_if_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(s0_mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_ubhw(mem_req_ubhw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(s0_mem_rsp_valid), .mem_rsp_data(s0_mem_rsp_data),
    .ram_en(s0_ram_en), .ram_we(s0_ram_we), .ram_ubhw(s0_ram_ubhw), .ram_addr(s0_ram_addr),
    .ram_wdata(s0_ram_wdata), .ram_rdata(32'h0),
    .perf_conflicts(s0_perf_conflicts), .perf_if_wait(s0_perf_if_wait)
  );

  // RAM model with RD_LAT=2 read latency
  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd_p0 = 32'h0, rd_p1 = 32'h0;

  always @(posedge clk) begin
    if (ram_en && ram_we) ram[ram_addr[9:2]] <= ram_wdata;
    rd_p0 <= (ram_en && !ram_we) ? ram[ram_addr[9:2]] : 32'h0;
    rd_p1 <= rd_p0;
  end
  assign ram_rdata = rd_p1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire responses against the scoreboard, then log this cycle's grant.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      chk("rst_ctrl", {24'h0, if_req_ready, mem_req_ready, if_rsp_valid, mem_rsp_valid,
                       ram_en, ram_we, ram_ubhw != 3'b0}, 32'h0);
      chk("rst_data", if_rsp_data | mem_rsp_data | ram_addr | ram_wdata, 32'h0);
      chk("rst_perf", perf_conflicts | perf_if_wait, 32'h0);
    end else begin
      chk("rdy_excl", {31'h0, if_req_ready && mem_req_ready}, 32'h0);
      chk("rsp_excl", {31'h0, if_rsp_valid && mem_rsp_valid}, 32'h0);
      if (if_rsp_valid || mem_rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", {31'h0, 1'b1}, 32'h0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_owner", {31'h0, mem_rsp_valid}, {31'h0, e.owner});
          chk("rsp_data", if_rsp_valid ? if_rsp_data : mem_rsp_data, e.data);
          chk("rsp_cycle", cyc, e.due);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        chk("ram_addr", ram_addr, mem_addr);
        chk("ram_ctl", {27'h0, ram_en, ram_we, ram_ubhw}, {27'h0, 1'b1, mem_req_we, mem_req_ubhw});
        if (mem_req_we) begin
          chk("ram_wdata", ram_wdata, mem_wdata);
          sbq.push_back('{owner: 1'b1, data: 32'h0, due: cyc + RD_LAT});
          ref_mem[mem_addr[9:2]] = mem_wdata;
        end else begin
          sbq.push_back('{owner: 1'b1, data: ref_mem[mem_addr[9:2]], due: cyc + RD_LAT});
        end
      end else if (if_req_valid && if_req_ready) begin
        chk("ram_addr", ram_addr, if_addr);
        chk("ram_ctl", {27'h0, ram_en, ram_we, ram_ubhw}, {27'h0, 1'b1, 1'b0, 3'b010});
        sbq.push_back('{owner: 1'b0, data: ref_mem[if_addr[9:2]], due: cyc + RD_LAT});
      end else begin
        chk("ram_idle", {30'h0, ram_en, ram_we}, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy_chk(input string tag, input logic exp_if, input logic exp_mem);
    @(negedge clk);
    chk({tag, "_if_rdy"}, {31'h0, if_req_ready}, {31'h0, exp_if});
    chk({tag, "_mem_rdy"}, {31'h0, mem_req_ready}, {31'h0, exp_mem});
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    if_req_valid = 1'b0;
    mem_req_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'hC0DE_0000 + i;
      ref_mem[i] = 32'hC0DE_0000 + i;
    end
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = 32'h0;
    mem_req_valid = 1'b0; mem_req_we = 1'b0; mem_req_ubhw = 3'b010;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    step();
    step();
    rst = 1'b0;

    // 1: IF-only stream
    for (int i = 0; i < 3; i++) begin
      if_req_valid = 1'b1;
      if_addr = 32'(i * 4);
      rdy_chk("t1", 1'b1, 1'b0);
      step();
    end
    if_req_valid = 1'b0;
    repeat (4) step();

    // 2: single-cycle conflict, MEM first then IF
    if_req_valid = 1'b1; if_addr = 32'hC;
    mem_req_valid = 1'b1; mem_addr = 32'h100;
    rdy_chk("t2a", 1'b0, 1'b1);
    step();
    mem_req_valid = 1'b0;
    rdy_chk("t2b", 1'b1, 1'b0);
    step();
    if_req_valid = 1'b0;
    repeat (4) step();

    // 3: continuous conflict from a clean reset
    pulse_rst();
    if_req_valid = 1'b1; if_addr = 32'h20;
    mem_req_valid = 1'b1; mem_addr = 32'h104;
    for (int k = 0; k < 8; k++) begin
      rdy_chk("t3", (k % 4) == 3, (k % 4) != 3);
`ifdef RV32_ARB_PERF_EN
      chk("t3_perf_conf", perf_conflicts, 32'(k));
`else
      chk("t3_perf_conf", perf_conflicts, 32'h0);
`endif
      step();
    end
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    repeat (4) step();

    // 4: store then load to the same word
    mem_req_valid = 1'b1; mem_req_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
    rdy_chk("t4_st", 1'b0, 1'b1);
    chk("t4_st_we", {31'h0, ram_we}, 32'h1);
    step();
    mem_req_we = 1'b0; mem_wdata = 32'h0;
    rdy_chk("t4_ld", 1'b0, 1'b1);
    chk("t4_ld_we", {31'h0, ram_we}, 32'h0);
    step();
    mem_req_valid = 1'b0;
    repeat (4) step();

    // 5: reset with reads in flight while the FSM sits in IF_PRI
    if_req_valid = 1'b1; if_addr = 32'h24;
    mem_req_valid = 1'b1; mem_addr = 32'h108;
    for (int k = 0; k < 3; k++) begin
      rdy_chk("t5_pre", 1'b0, 1'b1);
      step();
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdy_chk("t5_post", k == 3, k != 3);
      step();
    end
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    repeat (4) step();

    // 6: strict MEM priority instance never grants IF under conflict
    pulse_rst();
    if_req_valid = 1'b1; if_addr = 32'h28;
    mem_req_valid = 1'b1; mem_addr = 32'h10C;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t6_if_rdy", {31'h0, s0_if_req_ready}, 32'h0);
      chk("t6_mem_rdy", {31'h0, s0_mem_req_ready}, 32'h1);
      step();
    end
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    @(negedge clk);
`ifdef RV32_ARB_PERF_EN
    chk("t6_perf_if_wait", s0_perf_if_wait, 32'd10);
`else
    chk("t6_perf_if_wait", s0_perf_if_wait, 32'h0);
`endif
    repeat (5) step();

    @(negedge clk);
    chk("sb_drained", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
